// File: rtl/scan_sequencer.sv
// Channel-select sequencer for the 2-to-4 decoder: walks the enabled channels in
// ascending cyclic order, holding each for a latched dwell count.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_one_shot,
  input  logic [3:0]         i_chan_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [1:0]         o_sel,
  output logic               o_sel_valid,
  output logic               o_busy,
  output logic               o_wrap,
  output logic               o_done,
  output logic               o_err
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DWELL = 1'b1;

  logic               r_state;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_one_shot;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         r_sel;
  logic               r_sel_valid;
  logic               r_busy;
  logic               r_wrap;
  logic               r_done;
  logic               r_err;

  logic [1:0]         w_next;
  logic               w_wraps;
  logic [DWELL_W-1:0] w_dwell_eff;

  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    if (m[0])      f_lowest = 2'd0;
    else if (m[1]) f_lowest = 2'd1;
    else if (m[2]) f_lowest = 2'd2;
    else           f_lowest = 2'd3;
  endfunction

  // Descending search leaves the lowest enabled channel above sel; none found means wrap.
  always_comb begin
    w_next  = f_lowest(r_mask);
    w_wraps = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_next  = i[1:0];
        w_wraps = 1'b0;
      end
    end
  end

  assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_dwell     <= DWELL_W'(1);
      r_one_shot  <= 1'b0;
      r_cnt       <= '0;
      r_sel       <= 2'b00;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_stop && i_start) begin
            if (i_chan_mask != 4'b0000) begin
              r_mask      <= i_chan_mask;
              r_dwell     <= w_dwell_eff;
              r_one_shot  <= i_one_shot;
              r_sel       <= f_lowest(i_chan_mask);
              r_cnt       <= w_dwell_eff - DWELL_W'(1);
              r_sel_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_DWELL;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          if (i_stop) begin
            r_state     <= ST_IDLE;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (w_wraps && r_one_shot) begin
            r_state     <= ST_IDLE;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_sel  <= w_next;
            r_cnt  <= r_dwell - DWELL_W'(1);
            r_wrap <= w_wraps;
          end
        end
      endcase
    end
  end

  assign o_sel       = r_sel;
  assign o_sel_valid = r_sel_valid;
  assign o_busy      = r_busy;
  assign o_wrap      = r_wrap;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; outputs are packed as {0,sel,valid,busy,wrap,done,err}.
module tb_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       one_shot;
  logic [3:0] chan_mask;
  logic [7:0] dwell;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       wrap;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] cont_sel [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3,
                                2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
  logic [1:0] os_sel   [4]  = '{2'd1, 2'd1, 2'd2, 2'd2};

  scan_sequencer #(.DWELL_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_one_shot  (one_shot),
    .i_chan_mask (chan_mask),
    .i_dwell     (dwell),
    .o_sel       (sel),
    .o_sel_valid (sel_valid),
    .o_busy      (busy),
    .o_wrap      (wrap),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %02h exp %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, sel, sel_valid, busy, wrap, done, err};
  endfunction

  function automatic logic [7:0] ex(input logic [1:0] s, input logic v, input logic b,
                                    input logic w, input logic d, input logic e);
    return {1'b0, s, v, b, w, d, e};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
    chan_mask = 4'b0000; dwell = 8'd0;
    #2 rst_n = 1'b0;
    #1 check("reset_init", outs(), ex(2'd0, 0, 0, 0, 0, 0));
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("idle_after_reset", outs(), ex(2'd0, 0, 0, 0, 0, 0));

    // Continuous 1011, dwell 3; config inputs scrambled mid-scan must be ignored.
    chan_mask = 4'b1011; dwell = 8'd3; one_shot = 1'b0; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      start = 1'b0;
      if (i == 2) begin chan_mask = 4'b0001; dwell = 8'd1; one_shot = 1'b1; end
      check($sformatf("cont%0d", i), outs(), ex(cont_sel[i], 1, 1, (i == 9), 0, 0));
    end
    rst_n = 1'b0;
    #1 check("reset_mid_scan", outs(), ex(2'd0, 0, 0, 0, 0, 0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_post%0d", i), outs(), ex(2'd0, 0, 0, 0, 0, 0));
    end

    // One-shot 0110, dwell 2, followed back-to-back by continuous 1111, dwell 0.
    chan_mask = 4'b0110; dwell = 8'd2; one_shot = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      check($sformatf("os%0d", i), outs(), ex(os_sel[i], 1, 1, 0, 0, 0));
    end
    step();
    check("os_done", outs(), ex(2'd2, 0, 0, 0, 1, 0));
    chan_mask = 4'b1111; dwell = 8'd0; one_shot = 1'b0; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      start = 1'b0;
      check($sformatf("fast%0d", i), outs(), ex(2'(i % 4), 1, 1, (i == 4 || i == 8), 0, 0));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("fast_stop", outs(), ex(2'd0, 0, 0, 0, 0, 0));

    // Empty mask raises err only; start with stop is ignored.
    chan_mask = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse", outs(), ex(2'd0, 0, 0, 0, 0, 1));
    step();
    check("err_clear", outs(), ex(2'd0, 0, 0, 0, 0, 0));
    chan_mask = 4'b1111; start = 1'b1; stop = 1'b1;
    step();
    check("start_stop", outs(), ex(2'd0, 0, 0, 0, 0, 0));
    start = 1'b0; stop = 1'b0;
    step();
    check("start_stop_after", outs(), ex(2'd0, 0, 0, 0, 0, 0));

    // Abort on the fourth cycle of a scan.
    chan_mask = 4'b1011; dwell = 8'd3; one_shot = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      check($sformatf("abort%0d", i), outs(), ex(cont_sel[i], 1, 1, 0, 0, 0));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_stop", outs(), ex(2'd1, 0, 0, 0, 0, 0));
    step();
    check("abort_hold", outs(), ex(2'd1, 0, 0, 0, 0, 0));

    // Single channel 0100, dwell 4: every advance wraps onto itself.
    chan_mask = 4'b0100; dwell = 8'd4; one_shot = 1'b0; start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      start = 1'b0;
      check($sformatf("single%0d", i), outs(), ex(2'd2, 1, 1, (i != 0 && i % 4 == 0), 0, 0));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("single_stop", outs(), ex(2'd2, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
